// File: rtl/div_iter.sv
// div_iter: iterative 32-step radix-2 restoring divider (DIV/DIVU/REM/REMU); optional DIV_ZERO_BYPASS_EN gives a 1-cycle divide-by-zero path
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);
    typedef enum logic [1:0] {IDLE, ZERO, ON, DONE} state_t;
`ifdef DIV_ZERO_BYPASS_EN
    localparam state_t ZERO_NEXT = ZERO;
`else
    localparam state_t ZERO_NEXT = ON;
`endif
    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d, orig_q, orig_d;
    logic        neg_q, neg_d, dsign_q, dsign_d, zero_q, zero_d, ready_q, ready_d;
    logic [63:0] result_q, result_d;
    logic [32:0] shifted, diff;
    logic [31:0] q_raw, r_raw, q_fix, r_fix;
    logic        last, s1, s2;
    // all state and datapath registers; rst clears to idle with outputs low
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            orig_q   <= '0;
            neg_q    <= 1'b0;
            dsign_q  <= 1'b0;
            zero_q   <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            orig_q   <= orig_d;
            neg_q    <= neg_d;
            dsign_q  <= dsign_d;
            zero_q   <= zero_d;
            ready_q  <= ready_d;
            result_q <= result_d;
        end
    end
    // next state: annul returns to idle, done waits for start to drop
    always_comb begin
        state_d = state_q;
        if (annul_i) state_d = IDLE;
        else begin
            case (state_q)
                IDLE: if (start_i) state_d = (opdata2_i == 32'd0) ? ZERO_NEXT : ON;
                ZERO: state_d = DONE;
                ON:   if (last) state_d = DONE;
                DONE: if (!start_i) state_d = IDLE;
            endcase
        end
    end
    // one restoring step: the dividend register shifts out its MSB and collects quotient bits
    always_comb begin
        shifted = {rem_q, dvd_q[31]};
        diff    = shifted - {1'b0, dvs_q};
        last    = cnt_q == 6'd31;
        q_raw   = {dvd_q[30:0], ~diff[32]};
        r_raw   = diff[32] ? shifted[31:0] : diff[31:0];
        q_fix   = neg_q ? -q_raw : q_raw;
        r_fix   = dsign_q ? -r_raw : r_raw;
        s1      = signed_div_i & opdata1_i[31];
        s2      = signed_div_i & opdata2_i[31];
    end
    // datapath and registered outputs per state
    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        orig_d   = orig_q;
        neg_d    = neg_q;
        dsign_d  = dsign_q;
        zero_d   = zero_q;
        ready_d  = ready_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (start_i) begin
                neg_d   = s1 ^ s2;
                dsign_d = s1;
                dvd_d   = s1 ? -opdata1_i : opdata1_i;
                dvs_d   = s2 ? -opdata2_i : opdata2_i;
                orig_d  = opdata1_i;
                zero_d  = opdata2_i == 32'd0;
                rem_d   = '0;
                cnt_d   = '0;
            end
            ZERO: begin
                ready_d  = 1'b1;
                result_d = {orig_q, 32'hFFFF_FFFF};
            end
            ON: begin
                rem_d = r_raw;
                dvd_d = q_raw;
                cnt_d = cnt_q + 6'd1;
                if (last) begin
                    ready_d  = 1'b1;
                    result_d = zero_q ? {orig_q, 32'hFFFF_FFFF} : {r_fix, q_fix};
                end
            end
            DONE: if (!start_i) begin
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
        if (annul_i) begin
            ready_d  = 1'b0;
            result_d = '0;
            cnt_d    = '0;
        end
    end
    assign ready_o  = ready_q;
    assign result_o = result_q;
endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-cycle radix-2 divider serving the execute stage of the RISC-V pipeline. It implements DIV, DIVU, REM and REMU with RISC-V results for divide-by-zero and signed overflow. Execute drives the operands and holds `start_i` while it stalls the pipeline. This block returns `{remainder, quotient}` on a 64-bit bus with a `ready_o` handshake. A pipeline flush aborts it via `annul_i`.

## Interface
- No parameters; operand width fixed at 32.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `signed_div_i` in 1: 1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with `start_i` in IDLE.
- `opdata1_i` in 32: dividend; sampled with `start_i` in IDLE.
- `opdata2_i` in 32: divisor; sampled with `start_i` in IDLE.
- `start_i` in 1: request; held high by execute until it observes `ready_o`.
- `annul_i` in 1: abort current operation (flush/trap).
- `result_o` out 64: `[63:32]` remainder, `[31:0]` quotient; valid while `ready_o`=1, else 0.
- `ready_o` out 1: result valid.

## Operation
- States: IDLE, ZERO, ON, DONE.
- Priority each edge: `rst` > `annul_i` > state logic.
- **rst or annul_i**: state→IDLE, `ready_o`=0, `result_o`=0, iteration counter=0.
- **IDLE**:
  - `start_i`=0: stay in IDLE.
  - `start_i`=1 and divisor≠0: latch the signs; latch |dividend| and |divisor| (magnitudes only when signed); clear the partial remainder (33 bit) and counter; →ON.
  - `start_i`=1 and divisor=0: →ZERO (see Configuration).
- **ON**: one restoring step per cycle.
  - Shift the dividend MSB into the partial remainder.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and shift in a quotient bit of 1; else shift in 0.
  - Counter increments; after step 32 →DONE.
- **Sign fix at DONE entry**, signed only:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend sign.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF): the natural datapath yields q=0x80000000, r=0. No special case is needed.
- **Divide by zero**: q=0xFFFFFFFF, r=dividend (original, unsigned or signed alike).
- **DONE**:
  - `ready_o`=1 and `result_o` is held.
  - If `start_i`=0, →IDLE and outputs clear next edge.
  - If `start_i`=1, stay in DONE. No new operation starts until `start_i` has dropped.
- Operands changing during ON are ignored; only the values latched in IDLE matter.
- Only the absolute value of 0x80000000 needs 32-bit unsigned treatment (magnitude 0x80000000). The datapath must not sign-extend it wrongly.

## Timing
- Edge E0 samples `start_i`=1 in IDLE; in the normal path, E1–E32 perform the iterations.
- `ready_o` rises after E32: it is first high in the cycle following E32, i.e. 32 cycles after the sampling edge.
- `ready_o` falls the cycle after the edge where `start_i`=0 is seen in DONE.
- Back-to-back: the earliest new `start_i` sample is the edge after the return to IDLE.
- `annul_i` at any edge: `ready_o`=0 from the next cycle; a `start_i` on the same edge is ignored.
- `rst` mid-operation: identical to `annul_i`.
- Outputs are fully registered; there is no combinational path from inputs to `ready_o`/`result_o`.

## Configuration
- `DIV_ZERO_BYPASS_EN` defined:
  - ZERO is a single-cycle state that writes the divide-by-zero result and goes to DONE.
  - `ready_o` is high in the cycle after E1, i.e. latency 1.
- `DIV_ZERO_BYPASS_EN` undefined:
  - ZERO is not used; divisor=0 enters ON like any other operation and runs all 32 steps.
  - At DONE entry the result is overridden to q=0xFFFFFFFF, r=dividend. The sign fix is not applied on this path.
  - Latency is 32, uniform for all operands.

## Test plan
- Unsigned 100/7, `start_i` held → `ready_o` after exactly 32 cycles, `result_o`=0x00000002_0000000E; drop `start_i` → `ready_o`=0 and `result_o`=0 one cycle later.
- Signed 0xFFFFFFF9 (−7) / 2 → q=0xFFFFFFFD, r=0xFFFFFFFF; unsigned of same operands → q=0x7FFFFFFC, r=0x00000001.
- Signed 0xFFFFFFFB (−5) / 0 → q=0xFFFFFFFF, r=0xFFFFFFFB.
  - With `DIV_ZERO_BYPASS_EN`: ready 1 cycle after E1.
  - Without `DIV_ZERO_BYPASS_EN`: ready after 32 cycles.
- Signed 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0x00000000.
- Pulse `annul_i` at iteration 10 with `start_i` still high → `ready_o` never asserts, state IDLE. Hold `start_i` for new 9/3 → after 32 cycles, q=3, r=0.
- Hold `start_i` high 5 cycles in DONE → `ready_o` and `result_o` stable throughout. Assert `rst` in DONE → next cycle `ready_o`=0 and `result_o`=0.
